// File: rtl/pagerank_dual_port_mem_responder.sv
// pagerank_dual_port_mem_responder: two-port word memory answering vc mem requests.
// Each port has its own 2-entry in-order response queue; both share one array.
module pagerank_dual_port_mem_responder #(
   parameter int NWORDS = 256,
   parameter int AW     = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [76:0] mem_req0_msg,
   input  logic        mem_req0_val,
   output logic        mem_req0_rdy,
   output logic [46:0] mem_resp0_msg,
   output logic        mem_resp0_val,
   input  logic        mem_resp0_rdy,
   input  logic [76:0] mem_req1_msg,
   input  logic        mem_req1_val,
   output logic        mem_req1_rdy,
   output logic [46:0] mem_resp1_msg,
   output logic        mem_resp1_val,
   input  logic        mem_resp1_rdy
);
   logic [31:0]   mem [NWORDS];
   logic [76:0]   req [2];
   logic [46:0]   q [2][2];
   logic [46:0]   resp [2];
   logic [1:0]    cnt [2];
   logic [AW-1:0] idx [2];
   logic [1:0]    req_val, resp_rdy, rdy, val, acc, deq, hd;
   logic          unused;

   assign req      = '{mem_req0_msg, mem_req1_msg};
   assign req_val  = {mem_req1_val, mem_req0_val};
   assign resp_rdy = {mem_resp1_rdy, mem_resp0_rdy};
   assign unused   = ^{req[0][65:AW+36], req[0][35:34], req[1][65:AW+36], req[1][35:34]};

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         idx[p]  = req[p][AW+35:36];
         rdy[p]  = !reset && cnt[p] != 2'd2;
         val[p]  = !reset && cnt[p] != 2'd0;
         acc[p]  = req_val[p] && rdy[p];
         deq[p]  = val[p] && resp_rdy[p];
         resp[p] = {req[p][76:66], 2'b00, req[p][33:32],
                    req[p][76:74] == 3'd0 ? mem[idx[p]] : 32'd0};
      end
   end

   assign mem_req0_rdy  = rdy[0];
   assign mem_req1_rdy  = rdy[1];
   assign mem_resp0_val = val[0];
   assign mem_resp1_val = val[1];
   assign mem_resp0_msg = val[0] ? q[0][hd[0]] : '0;
   assign mem_resp1_msg = val[1] ? q[1][hd[1]] : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '{2'd0, 2'd0};
         hd  <= '0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (acc[p]) q[p][hd[p] ^ cnt[p][0]] <= resp[p];
            hd[p]  <= hd[p] ^ deq[p];
            cnt[p] <= cnt[p] + 2'(acc[p]) - 2'(deq[p]);
         end
      end
   end

   // Port 1 is applied last so it wins a same-word write collision.
   always_ff @(posedge clk) begin
      for (int p = 0; p < 2; p++)
         if (acc[p] && req[p][76:74] == 3'd1) mem[idx[p]] <= req[p][31:0];
   end
endmodule

// File: doc/pagerank_dual_port_mem_responder.md
Name: pagerank_dual_port_mem_responder

Overview:
- Two-port on-chip word memory that services vc mem request messages (opaque 8, addr 32, data 32) and returns vc mem response messages (opaque 8, data 32) over val/rdy.
- It is the responder end of the scheduler's two memory ports, and holds the graph matrix G and the rank vector R for PageRank.
- Each port has an independent request path and a 2-entry response queue.
- Both ports share one storage array.

Parameters:
- NWORDS, 256: number of 32-bit words of storage (power of 2).
- AW, 8: word-index width, equal to log2(NWORDS).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mem_req0_msg  in  77  port-0 request {type[76:74], opaque[73:66], addr[65:34], len[33:32], data[31:0]}
- mem_req0_val  in  1  port-0 request valid
- mem_req0_rdy  out  1  port-0 request ready
- mem_resp0_msg  out  47  port-0 response {type[46:44], opaque[43:36], test[35:34], len[33:32], data[31:0]}
- mem_resp0_val  out  1  port-0 response valid
- mem_resp0_rdy  in  1  port-0 response ready
- mem_req1_msg, mem_req1_val, mem_req1_rdy, mem_resp1_msg, mem_resp1_val, mem_resp1_rdy: identical to port 0, for port 1.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset values: all outputs are 0 while reset is high, including req_rdy and resp_val. Both response queues are emptied. Storage contents are NOT cleared.
- First cycle after reset: req_rdy = 1 on both ports.
- Request handshake: a request is accepted on a port when req_val && req_rdy at a posedge.
  - req_rdy = (that port's response-queue count < 2).
  - req_rdy has no combinational dependence on resp_rdy or req_val.
- Word index: addr[AW+1:2]. addr[1:0] and addr[31:AW+2] are ignored, so accesses wrap modulo NWORDS.
- len: echoed in the response only. All accesses are full 32-bit words.
- Type 0 (read): response data = mem[index] as it was before any write in the same cycle.
- Type 1 (write): mem[index] <= req data at the accepting edge. Response data = 0.
- Types 2-7: no storage effect. Response data = 0. The type is echoed.
- Every response: type and opaque echo the request, test = 2'b00.
- Latency: a request accepted at edge t has its response pushed into the queue at edge t; resp_val is high from cycle t+1. With resp_rdy held at 1, each port sustains 1 request per cycle.
- Response queue: 2-entry FIFO per port, in-order.
  - resp_val = (count != 0); resp_msg = head entry.
  - Dequeue on resp_val && resp_rdy.
  - Simultaneous enqueue and dequeue leaves the count unchanged.
  - A full queue (count = 2) deasserts req_rdy until a dequeue.
- Both ports write the same word in the same cycle: port 1's data is stored.
- Port 0 reads while port 1 writes the same word, or vice versa: the read returns the old value.
- Ports do not order against each other; each port's responses are strictly in its own request order.
- Reset mid-operation: queued responses are discarded. Writes accepted before reset remain in storage.
- Storage: 2-write / 2-read array with synchronous write. Read data is captured into the queue at the accepting edge.

Test Plan:
- Write then read, port 0: write addr 0x10, data 0xDEADBEEF, opaque 0x05 -> response type 1, opaque 0x05, data 0. Then read 0x10 with opaque 0x06 -> response type 0, opaque 0x06, data 0xDEADBEEF one cycle after acceptance.
- Cross-port visibility: port 0 writes addr 0x20, data 0x12345678. The next cycle port 1 reads 0x20 -> port 1 response data 0x12345678.
- Back-pressure, port 1: hold resp_rdy = 0 and issue 3 reads (0x0, 0x4, 0x8) -> req_rdy drops after the 2nd acceptance. Raise resp_rdy -> responses arrive in order and the 3rd request is accepted the cycle after the first dequeue.
- Same-word conflict: in the same cycle, port 0 writes 0x30 = 0xAAAA0000 and port 1 writes 0x30 = 0x0000BBBB. A later read of 0x30 -> 0x0000BBBB.
- Read-during-write: mem[0x40] = 0x1. In the same cycle, port 0 writes 0x40 = 0x2 and port 1 reads 0x40 -> port 1 data 0x1. A later read -> 0x2.
- Wrap and reset: with NWORDS = 256, write addr 0x400 with 0x77 and read addr 0x0 -> 0x77. Assert reset with 2 queued responses -> resp_val = 0 and the queue is empty after reset, and mem[0] is still 0x77.
